gerador_semente: RTL
====================

Name: gerador_semente

Overview:
Upstream producer for the one-hot number generator. It runs a free-running 16-bit LFSR and, on request, draws a 4-bit seed in 0..MAX_VAL by rejection sampling. It then holds `seed` stable and strobes `gerar` one cycle later, so the downstream stage latches a valid seed on the rising edge of `gerar`. Optionally it forbids repeating the previous seed.

Parameters:
- LFSR_INIT, 16'hACE1: LFSR value loaded on reset. Zero is legal; the zero-lock guard recovers from it.
- MAX_VAL, 10: largest legal seed, range 1..14.
- MAX_TRIES, 8: rejection attempts before the deterministic fallback, minimum 1.
- NO_REPEAT, 1: when 1, a seed never equals the previous delivered seed.

Ports:
- clk  in  1  system clock; all logic updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pedir  in  1  request; sampled only in OCIOSO.
- entropia  in  1  asynchronous user input, e.g. a button, already synchronised upstream; XORed into the LFSR feedback.
- seed  out  4  drawn seed; drives the downstream seed input.
- gerar  out  1  one-cycle strobe; drives the downstream gerar input.
- ocupado  out  1  high while a request is in progress.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - lfsr=LFSR_INIT, state=OCIOSO.
  - seed=0, gerar=0, ocupado=0, tries=0.
  - last_valid=0, last=0.
  - Reset mid-request aborts it immediately; no `gerar` is emitted.
- LFSR:
  - Advances every non-reset cycle, in every state.
  - Update: lfsr <= {lfsr[14:0], fb}, with fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]^entropia.
  - Zero-lock guard: if lfsr==0, the next value is 16'hACE1 instead of the shift.
- Candidate: c = lfsr[3:0], the registered value in the current cycle.
- Accept rule: c<=MAX_VAL AND (NO_REPEAT==0 OR last_valid==0 OR c!=last).
- FSM, `ocupado` = (state != OCIOSO):
  - OCIOSO: `gerar`=0. If `pedir`=1, go to BUSCA with tries=0. Otherwise stay.
  - BUSCA, when the accept rule holds: seed<=c, last<=c, last_valid<=1, go to ESTAVEL.
  - BUSCA, when it fails and tries<MAX_TRIES-1: tries<=tries+1, stay in BUSCA.
  - BUSCA, when it fails and tries==MAX_TRIES-1 (fallback):
    - f = (c>MAX_VAL) ? c-(MAX_VAL+1) : c.
    - If NO_REPEAT and last_valid and f==last, then f = (f==MAX_VAL) ? 0 : f+1.
    - seed<=f, last<=f, last_valid<=1, go to ESTAVEL.
  - ESTAVEL: `seed` is held and `gerar`=0 for exactly 1 cycle (setup for the downstream edge). Go to PULSO.
  - PULSO: `gerar`=1 for exactly 1 cycle, `seed` held. Go to OCIOSO.
- Request handling:
  - `pedir` is ignored while ocupado=1; requests are neither queued nor counted.
  - `pedir` held high yields back-to-back requests. Each request is re-sampled in the OCIOSO cycle following PULSO.
- Latency:
  - From `pedir` sampled in OCIOSO to `gerar` high: 3 cycles with no rejections, plus 1 cycle per rejection.
  - Maximum is MAX_TRIES+2 cycles.
- Output timing: `seed` changes only on the BUSCA-exit edge, and is stable from ESTAVEL through the end of PULSO and afterwards.
- Registers and widths:
  - `tries` is a counter of width clog2(MAX_TRIES)+1.
  - All outputs are registered.
  - All comparisons are unsigned 4-bit.

Test Plan (entropia=0 unless stated):
1. Basic draw: LFSR_INIT=16'h0003. Hold `pedir`=1 in the first cycle after reset release, then low. BUSCA sees lfsr=16'h0006, so seed=6 on the next edge. `gerar`=1 exactly 3 cycles after the `pedir` cycle and for 1 cycle only. `ocupado`=1 for cycles 1..3.
2. Boundary and rejection:
   - LFSR_INIT=16'h0005: candidate 10 (=MAX_VAL) is accepted; seed=10.
   - LFSR_INIT=16'h0006: candidate 12 is rejected, then 8 is accepted; seed=8, and `gerar` is 1 cycle later than in scenario 1.
3. Fallback: MAX_TRIES=1, LFSR_INIT=16'h0006. Candidate 12 forces the fallback: seed=1 with no retry cycle.
4. Zero-lock and reset: LFSR_INIT=16'h0000 gives lfsr=16'hACE1 one cycle after reset. Asserting `reset` during ESTAVEL gives `gerar`=0, seed=0 and `ocupado`=0 on the next cycle, and no pulse ever follows.
5. Randomised: `pedir` held high for 2000 requests with random `entropia` (NO_REPEAT=1). Every `gerar` pulse has seed<=10, no two consecutive seeds are equal, all 11 values appear, and `pedir` asserted while `ocupado`=1 never causes an extra pulse.

Source files
------------

// File: rtl/gerador_semente.sv
// Seed producer for the one-hot generator: free-running 16-bit LFSR, rejection
// sampling of a 4-bit seed in 0..MAX_VAL, then a held seed followed by a one-cycle gerar strobe.
module gerador_semente #(
  parameter logic [15:0] LFSR_INIT = 16'hACE1,
  parameter int unsigned MAX_VAL   = 10,
  parameter int unsigned MAX_TRIES = 8,
  parameter bit          NO_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedir,
  input  logic       entropia,
  output logic [3:0] seed,
  output logic       gerar,
  output logic       ocupado
);

  localparam int TW = $clog2(MAX_TRIES) + 1;
  localparam logic [3:0]    MAXV  = 4'(MAX_VAL);
  localparam logic [TW-1:0] TLAST = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {OCIOSO, BUSCA, ESTAVEL, PULSO} estado_t;

  estado_t       state_r, state_nx;
  logic [15:0]   lfsr_r;
  logic [TW-1:0] tries_r, tries_nx;
  logic [3:0]    seed_r, seed_nx;
  logic [3:0]    last_r, last_nx;
  logic          last_valid_r, last_valid_nx;
  logic          gerar_r;
  logic          ocupado_r;
  logic [3:0]    cand_s;
  logic          accept_s;
  logic [3:0]    fallback_s;

  // All-zero state would lock the shift register, so it is re-seeded instead.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v, input logic e);
    if (v == 16'h0000) begin
      lfsr_next = 16'hACE1;
    end else begin
      lfsr_next = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ e};
    end
  endfunction

  // Folds an out-of-range candidate into range and steps past the previous seed.
  function automatic logic [3:0] fold_seed(input logic [3:0] c, input logic [3:0] prev,
                                           input logic prev_ok);
    logic [3:0] f;
    if (c > MAXV) begin
      f = c - (MAXV + 4'd1);
    end else begin
      f = c;
    end
    if (NO_REPEAT && prev_ok && (f == prev)) begin
      fold_seed = (f == MAXV) ? 4'd0 : f + 4'd1;
    end else begin
      fold_seed = f;
    end
  endfunction

  // Candidate evaluation for the current BUSCA cycle.
  always_comb begin
    cand_s     = lfsr_r[3:0];
    accept_s   = (cand_s <= MAXV) &&
                 (!NO_REPEAT || !last_valid_r || (cand_s != last_r));
    fallback_s = fold_seed(cand_s, last_r, last_valid_r);
  end

  // Request FSM next-state and seed bookkeeping.
  always_comb begin
    state_nx      = state_r;
    tries_nx      = tries_r;
    seed_nx       = seed_r;
    last_nx       = last_r;
    last_valid_nx = last_valid_r;
    case (state_r)
      OCIOSO: begin
        if (pedir) begin
          state_nx = BUSCA;
          tries_nx = {TW{1'b0}};
        end else begin
          state_nx = OCIOSO;
        end
      end
      BUSCA: begin
        if (accept_s) begin
          seed_nx       = cand_s;
          last_nx       = cand_s;
          last_valid_nx = 1'b1;
          state_nx      = ESTAVEL;
        end else if (tries_r != TLAST) begin
          tries_nx = tries_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
          seed_nx       = fallback_s;
          last_nx       = fallback_s;
          last_valid_nx = 1'b1;
          state_nx      = ESTAVEL;
        end
      end
      ESTAVEL: state_nx = PULSO;
      PULSO:   state_nx = OCIOSO;
      default: state_nx = OCIOSO;
    endcase
  end

  // State, LFSR and registered outputs; gerar/ocupado are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r       <= LFSR_INIT;
      state_r      <= OCIOSO;
      tries_r      <= {TW{1'b0}};
      seed_r       <= 4'd0;
      last_r       <= 4'd0;
      last_valid_r <= 1'b0;
      gerar_r      <= 1'b0;
      ocupado_r    <= 1'b0;
    end else begin
      lfsr_r       <= lfsr_next(lfsr_r, entropia);
      state_r      <= state_nx;
      tries_r      <= tries_nx;
      seed_r       <= seed_nx;
      last_r       <= last_nx;
      last_valid_r <= last_valid_nx;
      gerar_r      <= (state_nx == PULSO);
      ocupado_r    <= (state_nx != OCIOSO);
    end
  end

  assign seed    = seed_r;
  assign gerar   = gerar_r;
  assign ocupado = ocupado_r;

endmodule
